// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory serial loader.
// LOADER_PARITY_EN adds an even-parity bit to every serial frame (8E1 instead of 8N1).
package imem_loader_pkg;
  typedef enum logic [1:0] {S_HDR, S_LEN, S_DATA, S_CSUM} state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_e;

  localparam logic [7:0] DEF_HEADER = 8'hA5;
`ifdef LOADER_PARITY_EN
  localparam int BITS_PER_FRAME = 11;
`else
  localparam int BITS_PER_FRAME = 10;
`endif
endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, mid-bit sampling timer, LSB-first shifter.
// LOADER_PARITY_EN: checks an even-parity bit before the stop bit; a mismatch reports frame_err.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    STOP_IDX = 4'(BITS_PER_FRAME - 2);

  logic [1:0]      sync_q;
  logic            prev_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d, ferr_q, ferr_d;
  logic            rx_s, par_ok;

  assign rx_s = sync_q[1];

`ifdef LOADER_PARITY_EN
  logic perr_q, perr_d;
  assign par_ok = !perr_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) perr_q <= 1'b0;
    else       perr_q <= perr_d;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef LOADER_PARITY_EN
    perr_d  = perr_q;
`endif
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s) state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        // A line that is high again at mid-start was a glitch.
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s ? RX_IDLE : RX_BITS;
`ifdef LOADER_PARITY_EN
        perr_d  = 1'b0;
`endif
      end
      RX_BITS: if (cnt_q == BIT_END) begin
        cnt_d = '0;
        bit_d = bit_q + 4'd1;
        if (bit_q < 4'd8) shift_d = {rx_s, shift_q[7:1]};
`ifdef LOADER_PARITY_EN
        if (bit_q == 4'd8) perr_d = rx_s ^ (^shift_q);
`endif
        // Idle again at the stop-bit sample so back-to-back bytes keep their timing.
        if (bit_q == STOP_IDX) begin
          state_d = RX_IDLE;
          if (rx_s && par_ok) valid_d = 1'b1;
          else                ferr_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = shift_q;
  assign frame_err_o  = ferr_q;
endmodule

// File: rtl/imem_serial_loader.sv
// Loads a HEADER/LEN/data/CSUM frame from a serial line into instruction memory and
// holds the core until a verified image is present. LOADER_PARITY_EN selects 8E1 framing.
module imem_serial_loader
  import imem_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         MEM_DEPTH    = 16,
  parameter int         ADDR_W       = 4,
  parameter logic [7:0] HEADER       = DEF_HEADER
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Rx,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [7:0]        Mem_Data,
  output logic              Cpu_Hold,
  output logic              Load_Done,
  output logic              Load_Error
);
  localparam logic [8:0] MAX_LEN = 9'(MEM_DEPTH);

  logic       bv, ferr;
  logic [7:0] rx_byte;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .rx_i        (Rx),
    .byte_valid_o(bv),
    .byte_o      (rx_byte),
    .frame_err_o (ferr)
  );

  state_e            state_q, state_d;
  logic [8:0]        len_q, len_d, cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d, data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic              fail;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_HDR;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    fail    = 1'b0;
    unique case (state_q)
      S_HDR: if (bv && rx_byte == HEADER) begin
        state_d = S_LEN;
        hold_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        sum_d   = '0;
      end
      S_LEN: if (bv) begin
        if (rx_byte != 8'd0 && {1'b0, rx_byte} <= MAX_LEN) begin
          len_d   = {1'b0, rx_byte};
          cnt_d   = '0;
          state_d = S_DATA;
        end else fail = 1'b1;
      end
      // Leave only after the last write strobe has gone out, so WE stays inside S_DATA.
      S_DATA: if (cnt_q == len_q) state_d = S_CSUM;
      else if (bv) begin
        we_d   = 1'b1;
        addr_d = cnt_q[ADDR_W-1:0];
        data_d = rx_byte;
        sum_d  = sum_q + rx_byte;
        cnt_d  = cnt_q + 9'd1;
      end
      S_CSUM: if (bv) begin
        if (rx_byte == sum_q) begin
          done_d  = 1'b1;
          hold_d  = 1'b0;
          state_d = S_HDR;
        end else fail = 1'b1;
      end
      default: state_d = S_HDR;
    endcase
    if (ferr && state_q != S_HDR) fail = 1'b1;
    if (fail) begin
      err_d   = 1'b1;
      hold_d  = 1'b1;
      done_d  = 1'b0;
      state_d = S_HDR;
    end
  end

  assign Mem_WE     = we_q;
  assign Mem_Addr   = addr_q;
  assign Mem_Data   = data_q;
  assign Cpu_Hold   = hold_q;
  assign Load_Done  = done_q;
  assign Load_Error = err_q;
endmodule

// File: tb/tb_imem_serial_loader.sv
// Bench for imem_serial_loader: table of whole frames plus hand-written corner sequences,
// with a write scoreboard fed from the frames the bench sends.
module tb_imem_serial_loader;
  localparam int CPB = 8;

  logic       Clock = 1'b0, Reset = 1'b1, Rx = 1'b1;
  logic       Mem_WE, Cpu_Hold, Load_Done, Load_Error;
  logic [3:0] Mem_Addr;
  logic [7:0] Mem_Data;

  always #5 Clock = ~Clock;

  imem_serial_loader #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(16), .ADDR_W(4), .HEADER(8'hA5)) dut (
    .Clock(Clock), .Reset(Reset), .Rx(Rx), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr),
    .Mem_Data(Mem_Data), .Cpu_Hold(Cpu_Hold), .Load_Done(Load_Done), .Load_Error(Load_Error)
  );

  int n_cmp = 0, n_bad = 0, bv_cnt = 0;

  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t sb[$];

  typedef struct {
    int         n;
    logic [7:0] b [20];
    bit         done, err, hold;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge Clock) if (dut.u_rx.byte_valid_o) bv_cnt++;

  always @(negedge Clock) begin
    wr_t e;
    if (!Reset && Mem_WE) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", Mem_Addr, Mem_Data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(Mem_Addr), 32'(e.a));
        chk("wr_data", 32'(Mem_Data), 32'(e.d));
      end
    end
  end

  task automatic send_bit(input logic b);
    Rx = b;
    repeat (CPB) @(negedge Clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef LOADER_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop);
    Rx = 1'b1;
    if (!stop) send_bit(1'b1);
  endtask

`ifdef LOADER_PARITY_EN
  task automatic send_byte_badpar(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b));
    send_bit(1'b1);
  endtask
`endif

  task automatic mk(input int i, input int n, input logic [7:0] a0, a1, a2, a3, a4, a5, a6,
                    input bit d, input bit e, input bit h);
    for (int k = 0; k < 20; k++) vt[i].b[k] = 8'h00;
    vt[i].b[0] = a0; vt[i].b[1] = a1; vt[i].b[2] = a2; vt[i].b[3] = a3;
    vt[i].b[4] = a4; vt[i].b[5] = a5; vt[i].b[6] = a6;
    vt[i].n = n; vt[i].done = d; vt[i].err = e; vt[i].hold = h;
  endtask

  task automatic push(input int a, input logic [7:0] d);
    sb.push_back({4'(a), d});
  endtask

  task automatic chk_out(input string nm, input bit d, input bit e, input bit h);
    chk({nm, "_done"}, 32'(Load_Done), 32'(d));
    chk({nm, "_err"},  32'(Load_Error), 32'(e));
    chk({nm, "_hold"}, 32'(Cpu_Hold), 32'(h));
    chk({nm, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  int         h, ln, t, c0;
  logic [7:0] s;

  initial begin
    mk(0, 6, 8'hA5, 8'h03, 8'h10, 8'h28, 8'h34, 8'h6C, 8'h00, 1, 0, 0);
    mk(1, 5, 8'hA5, 8'h02, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    mk(2, 4, 8'hA5, 8'h01, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    mk(3, 2, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    mk(4, 2, 8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    mk(5, 7, 8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'h01, 8'hA6, 1, 0, 0);
    mk(6, 19, 8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    s = 8'h00;
    for (int k = 0; k < 16; k++) begin
      vt[6].b[2+k] = 8'(k * 17 + 3);
      s = s + vt[6].b[2+k];
    end
    vt[6].b[18] = s;

    @(negedge Clock);
    chk("rst_we", 32'(Mem_WE), 0);
    chk("rst_addr", 32'(Mem_Addr), 0);
    chk("rst_data", 32'(Mem_Data), 0);
    chk_out("rst", 0, 0, 1);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);

    for (int v = 0; v < 7; v++) begin
      h = 0;
      while (vt[v].b[h] != 8'hA5) h++;
      ln = int'(vt[v].b[h+1]);
      if (ln >= 1 && ln <= 16)
        for (int k = 0; k < ln; k++) push(k, vt[v].b[h+2+k]);
      for (int k = 0; k < vt[v].n; k++) send_byte(vt[v].b[k], 1'b1);
      repeat (4) @(negedge Clock);
      chk_out($sformatf("vec%0d", v), vt[v].done, vt[v].err, vt[v].hold);
    end

    // Short low glitch must not produce a byte.
    c0 = bv_cnt;
    Rx = 1'b0;
    repeat (2) @(negedge Clock);
    Rx = 1'b1;
    repeat (3 * CPB) @(negedge Clock);
    chk("glitch_no_byte", 32'(bv_cnt), 32'(c0));
    chk_out("glitch", 1, 0, 0);

    // Cpu_Hold must drop exactly one cycle after the checksum byte is received.
    push(0, 8'h10); push(1, 8'h28); push(2, 8'h34);
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h10, 1);
    send_byte(8'h28, 1); send_byte(8'h34, 1);
    t = 0;
    fork
      send_byte(8'h6C, 1'b1);
      begin
        @(negedge Clock);
        while (!dut.u_rx.byte_valid_o && t < 20 * CPB) begin
          @(negedge Clock);
          t++;
        end
        chk("csum_bv_in_time", 32'(t < 20 * CPB), 1);
        chk("hold_at_csum_bv", 32'(Cpu_Hold), 1);
        @(negedge Clock);
        chk("hold_after_csum", 32'(Cpu_Hold), 0);
        chk("done_after_csum", 32'(Load_Done), 1);
      end
    join
    repeat (4) @(negedge Clock);

    // Stop bit forced low during the data phase.
    push(0, 8'h11);
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h11, 1); send_byte(8'h22, 1'b0);
    repeat (4) @(negedge Clock);
    chk_out("stop0", 0, 1, 1);

    // Reset after the second data byte, then a clean reload from address 0.
    push(0, 8'h01); push(1, 8'h02);
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h01, 1); send_byte(8'h02, 1);
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("mid_rst_we", 32'(Mem_WE), 0);
    chk("mid_rst_addr", 32'(Mem_Addr), 0);
    chk("mid_rst_data", 32'(Mem_Data), 0);
    chk_out("mid_rst", 0, 0, 1);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    push(0, 8'h07); push(1, 8'h08);
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h07, 1);
    send_byte(8'h08, 1); send_byte(8'h0F, 1);
    repeat (4) @(negedge Clock);
    chk_out("reload", 1, 0, 0);

`ifdef LOADER_PARITY_EN
    push(0, 8'h07);
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h07, 1); send_byte(8'h07, 1);
    repeat (4) @(negedge Clock);
    chk_out("par_good", 1, 0, 0);
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte_badpar(8'h07);
    repeat (4) @(negedge Clock);
    chk_out("par_bad", 0, 1, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
